// File: rtl/cache_miss_ctrl_pkg.sv
// rtl/cache_miss_ctrl_pkg.sv - shared types and constants for the data-cache miss controller
package cache_miss_ctrl_pkg;

  localparam int WAYS         = 4;
  localparam int SETS         = 16;
  localparam int INDEX_WIDTH  = 4;
  localparam int OFFSET_WIDTH = 5;
  localparam int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH;

  localparam logic [OFFSET_WIDTH-1:0] LINE_OFFSET = '0;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    STALL
  } state_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } addr_t;

  function automatic logic [31:0] line_addr(input logic [TAG_WIDTH-1:0]   tag,
                                            input logic [INDEX_WIDTH-1:0] index);
    return {tag, index, LINE_OFFSET};
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_plru_tree4.sv
// rtl/cache_miss_ctrl_plru_tree4.sv - 4-way tree pseudo-LRU victim select and update
module plru_tree4 (
  input  logic [2:0] plru_state,
  input  logic [1:0] access_way,
  output logic [1:0] victim,
  output logic [2:0] plru_next
);

  // bit 0 picks the half, bit 1 the way within {0,1}, bit 2 the way within {2,3}
  always_comb begin
    victim = plru_state[0] ? {1'b1, plru_state[2]} : {1'b0, plru_state[1]};
  end

  always_comb begin
    plru_next = plru_state;
    if (!access_way[1]) begin
      plru_next[0] = 1'b1;
      plru_next[1] = (access_way == 2'd0);
    end else begin
      plru_next[0] = 1'b0;
      plru_next[2] = (access_way == 2'd2);
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - control FSM for the 4-way data cache: compare, writeback, allocate
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               ufp_addr,
  input  logic [3:0]                ufp_rmask,
  input  logic [3:0]                ufp_wmask,
  input  logic [WAYS*TAG_WIDTH-1:0] tag_rdata,
  input  logic [WAYS-1:0]           valid_rdata,
  input  logic [WAYS-1:0]           dirty_rdata,
  output logic [INDEX_WIDTH-1:0]    arr_index,
  output logic [WAYS-1:0]           arr_we,
  output logic                      arr_dirty_wdata,
  output logic                      fill_sel,
  output logic                      hit,
  output logic                      read,
  output logic                      write,
  output logic [1:0]                hit_way,
  output logic [31:0]               dfp_addr,
  output logic                      dfp_read,
  output logic                      dfp_write,
  input  logic                      dfp_resp
);

  state_t state_q, state_d;

  addr_t                  ufp_split;
  logic [OFFSET_WIDTH-1:0] unused_offset;
  logic                   req_valid;

  logic [TAG_WIDTH-1:0]   req_tag_q;
  logic [INDEX_WIDTH-1:0] req_index_q;
  logic [3:0]             rmask_q, wmask_q;
  logic [1:0]             victim_q;
  logic [TAG_WIDTH-1:0]   victim_tag_q;
  logic [2:0]             plru_q [SETS];

  logic [TAG_WIDTH-1:0]   tag_way [WAYS];
  logic [WAYS-1:0]        hit_vec;
  logic                   any_hit;
  logic [1:0]             hit_idx;
  logic [1:0]             first_invalid;
  logic                   all_valid;
  logic [1:0]             plru_victim;
  logic [2:0]             plru_next;
  logic [1:0]             miss_victim;
  logic                   victim_dirty;
  logic                   req_is_write;

  assign ufp_split     = ufp_addr;
  assign unused_offset = ufp_split.offset;
  assign req_valid     = |(ufp_rmask | ufp_wmask);
  assign req_is_write  = |wmask_q;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      tag_way[w] = tag_rdata[w*TAG_WIDTH +: TAG_WIDTH];
      hit_vec[w] = valid_rdata[w] && (tag_way[w] == req_tag_q);
    end
  end

  // Lowest-numbered match / invalid way wins; loops run high-to-low so the last write is lowest
  always_comb begin
    hit_idx       = 2'd0;
    first_invalid = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_idx = 2'(w);
      if (!valid_rdata[w]) first_invalid = 2'(w);
    end
  end

  assign any_hit      = |hit_vec;
  assign all_valid    = &valid_rdata;
  assign miss_victim  = all_valid ? plru_victim : first_invalid;
  assign victim_dirty = valid_rdata[miss_victim] && dirty_rdata[miss_victim];

  plru_tree4 u_plru (
    .plru_state (plru_q[req_index_q]),
    .access_way (hit_idx),
    .victim     (plru_victim),
    .plru_next  (plru_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (req_valid) state_d = COMPARE;
      COMPARE: begin
        if (any_hit)           state_d = IDLE;
        else if (victim_dirty) state_d = WRITEBACK;
        else                   state_d = ALLOCATE;
      end
      WRITEBACK: if (dfp_resp) state_d = ALLOCATE;
      ALLOCATE:  if (dfp_resp) state_d = STALL;
      STALL:     state_d = COMPARE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    arr_index       = (state_q == IDLE) ? ufp_split.index : req_index_q;
    arr_we          = '0;
    arr_dirty_wdata = 1'b0;
    fill_sel        = 1'b0;
    hit             = 1'b0;
    read            = 1'b0;
    write           = 1'b0;
    hit_way         = 2'd0;
    dfp_addr        = '0;
    dfp_read        = 1'b0;
    dfp_write       = 1'b0;
    unique case (state_q)
      COMPARE: begin
        if (any_hit) begin
          hit     = 1'b1;
          hit_way = hit_idx;
          write   = req_is_write;
          read    = (|rmask_q) && !req_is_write;
          if (req_is_write) begin
            arr_we          = WAYS'(1) << hit_idx;
            arr_dirty_wdata = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        dfp_addr  = line_addr(victim_tag_q, req_index_q);
      end
      ALLOCATE: begin
        dfp_read = 1'b1;
        dfp_addr = line_addr(req_tag_q, req_index_q);
        if (dfp_resp) begin
          arr_we   = WAYS'(1) << victim_q;
          fill_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request latch, victim capture and PLRU touch; fills are counted by the re-compare hit
  always_ff @(posedge clk) begin
    if (rst) begin
      req_tag_q    <= '0;
      req_index_q  <= '0;
      rmask_q      <= '0;
      wmask_q      <= '0;
      victim_q     <= '0;
      victim_tag_q <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        req_tag_q   <= ufp_split.tag;
        req_index_q <= ufp_split.index;
        rmask_q     <= ufp_rmask;
        wmask_q     <= ufp_wmask;
      end
      if (state_q == COMPARE) begin
        if (any_hit) begin
          plru_q[req_index_q] <= plru_next;
        end else begin
          victim_q     <= miss_victim;
          victim_tag_q <= tag_way[miss_victim];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - scoreboard bench for cache_miss_ctrl with SRAM, memory and cache model
module tb_cache_miss_ctrl;
  import cache_miss_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic [31:0]               ufp_addr;
  logic [3:0]                ufp_rmask, ufp_wmask;
  logic [WAYS*TAG_WIDTH-1:0] tag_rdata;
  logic [WAYS-1:0]           valid_rdata, dirty_rdata;
  logic [INDEX_WIDTH-1:0]    arr_index;
  logic [WAYS-1:0]           arr_we;
  logic                      arr_dirty_wdata, fill_sel, hit, read, write;
  logic [1:0]                hit_way;
  logic [31:0]               dfp_addr;
  logic                      dfp_read, dfp_write, dfp_resp;
  logic                      resp_mem, resp_spur;

  assign dfp_resp = resp_mem | resp_spur;

  cache_miss_ctrl dut (
    .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask),
    .tag_rdata(tag_rdata), .valid_rdata(valid_rdata), .dirty_rdata(dirty_rdata),
    .arr_index(arr_index), .arr_we(arr_we), .arr_dirty_wdata(arr_dirty_wdata),
    .fill_sel(fill_sel), .hit(hit), .read(read), .write(write), .hit_way(hit_way),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_resp(dfp_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Tag/valid/dirty SRAM with one-cycle read; the written tag is that of the request in flight
  logic [TAG_WIDTH-1:0] s_tag   [SETS][WAYS];
  logic [WAYS-1:0]      s_valid [SETS];
  logic [WAYS-1:0]      s_dirty [SETS];
  logic [TAG_WIDTH-1:0] cur_tag;
  logic                 sram_clr;

  always @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) tag_rdata[w*TAG_WIDTH +: TAG_WIDTH] <= s_tag[arr_index][w];
    valid_rdata <= s_valid[arr_index];
    dirty_rdata <= s_dirty[arr_index];
    if (sram_clr) begin
      for (int s = 0; s < SETS; s++) begin
        s_valid[s] <= '0;
        s_dirty[s] <= '0;
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (arr_we[w]) begin
          s_tag[arr_index][w]   <= cur_tag;
          s_valid[arr_index][w] <= 1'b1;
          s_dirty[arr_index][w] <= arr_dirty_wdata;
        end
      end
    end
  end

  // Memory responder: random latency, sometimes 10 cycles, driven just after the clock edge
  logic mem_hold = 1'b0;
  int   wait_left = -1;
  initial begin
    resp_mem = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_mem) begin
        resp_mem  = 1'b0;
        wait_left = -1;
      end else if (!rst && !mem_hold && (dfp_read || dfp_write)) begin
        if (wait_left < 0) wait_left = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 4));
        if (wait_left == 0) resp_mem = 1'b1;
        else                wait_left--;
      end else begin
        wait_left = -1;
      end
    end
  end

  // Reference model: cache contents and tree-PLRU bits per set
  typedef struct {
    int          kind;  // 0 hit, 1 writeback, 2 line read
    logic [31:0] addr;
    int          way;
    bit          rd;
    bit          wr;
  } exp_t;

  exp_t                 expq[$];
  logic [TAG_WIDTH-1:0] m_tag   [SETS][WAYS];
  bit                   m_valid [SETS][WAYS];
  bit                   m_dirty [SETS][WAYS];
  int                   m_b0 [SETS], m_b1 [SETS], m_b2 [SETS];

  task automatic model_plru_reset();
    for (int s = 0; s < SETS; s++) begin
      m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0;
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       output bit was_hit);
    int                   idx = int'(a[8:5]);
    logic [TAG_WIDTH-1:0] tg  = a[31:9];
    bit                   wr  = (wm != 0);
    bit                   rd  = (rm != 0) && (wm == 0);
    int                   w   = -1;
    exp_t                 e;
    for (int i = 0; i < WAYS; i++)
      if (w < 0 && m_valid[idx][i] && m_tag[idx][i] == tg) w = i;
    was_hit = (w >= 0);
    if (w < 0) begin
      for (int i = 0; i < WAYS; i++)
        if (w < 0 && !m_valid[idx][i]) w = i;
      if (w < 0) w = (m_b0[idx] == 0) ? m_b1[idx] : 2 + m_b2[idx];
      if (m_valid[idx][w] && m_dirty[idx][w]) begin
        e.kind = 1; e.addr = {m_tag[idx][w], 4'(idx), 5'b0}; e.way = w; e.rd = 0; e.wr = 0;
        expq.push_back(e);
      end
      e.kind = 2; e.addr = {tg, 4'(idx), 5'b0}; e.way = w; e.rd = 0; e.wr = 0;
      expq.push_back(e);
      m_tag[idx][w]   = tg;
      m_valid[idx][w] = 1;
      m_dirty[idx][w] = 0;
    end
    e.kind = 0; e.addr = 0; e.way = w; e.rd = rd; e.wr = wr;
    expq.push_back(e);
    if (wr) m_dirty[idx][w] = 1;
    if (w < 2) begin
      m_b0[idx] = 1; m_b1[idx] = (w == 0) ? 1 : 0;
    end else begin
      m_b0[idx] = 0; m_b2[idx] = (w == 2) ? 1 : 0;
    end
  endtask

  // Monitor: pops the next expected event whenever the DUT presents one
  bit          mon_en = 1'b0;
  bit          prev_r = 1'b0, prev_w = 1'b0;
  logic [31:0] prev_addr = '0;
  int          fill_way = 0;

  task automatic pop_exp(input int kind, input string name, output exp_t e, output bit ok);
    ok = 0;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event actual=none-expected required=kind%0d", name, kind);
    end else if (expq[0].kind != kind) begin
      errors++;
      $display("FAIL %s event order actual=kind%0d required=kind%0d", name, kind, expq[0].kind);
      void'(expq.pop_front());
    end else begin
      e  = expq.pop_front();
      ok = 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (mon_en && !rst) begin
      if (dfp_read || dfp_write) check("dfp_exclusive", {31'd0, dfp_read & dfp_write}, 32'd0);
      if ((dfp_read && prev_r) || (dfp_write && prev_w)) check("dfp_addr_stable", dfp_addr, prev_addr);
      if (dfp_write && !prev_w) begin
        pop_exp(1, "writeback", e, ok);
        if (ok) check("wb_addr", dfp_addr, e.addr);
      end
      if (dfp_read && !prev_r) begin
        pop_exp(2, "allocate", e, ok);
        if (ok) begin
          check("alloc_addr", dfp_addr, e.addr);
          fill_way = e.way;
        end
      end
      if (dfp_read && dfp_resp) begin
        check("fill_we", {28'd0, arr_we}, 32'd1 << fill_way);
        check("fill_sel", {31'd0, fill_sel}, 32'd1);
        check("fill_dirty", {31'd0, arr_dirty_wdata}, 32'd0);
      end
      if (dfp_resp && !dfp_read && !hit) check("spurious_we", {28'd0, arr_we}, 32'd0);
      if (hit) begin
        pop_exp(0, "hit", e, ok);
        if (ok) begin
          check("hit_way", {30'd0, hit_way}, e.way);
          check("hit_read", {31'd0, read}, {31'd0, e.rd});
          check("hit_write", {31'd0, write}, {31'd0, e.wr});
          check("hit_we", {28'd0, arr_we}, e.wr ? (32'd1 << e.way) : 32'd0);
          check("hit_dirty", {31'd0, arr_dirty_wdata}, {31'd0, e.wr});
        end
      end
    end
    prev_r    = dfp_read;
    prev_w    = dfp_write;
    prev_addr = dfp_addr;
  end

  // Driver: one request at a time, held until the hit
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input bit spur);
    bit exp_hit;
    int n = 0;
    model(a, rm, wm, exp_hit);
    cur_tag   = a[31:9];
    ufp_addr  = a;
    ufp_rmask = rm;
    ufp_wmask = wm;
    if (spur) begin
      @(posedge clk);
      #2 resp_spur = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!hit && n < 400);
    resp_spur = 1'b0;
    if (!hit) check("req_timeout", 32'(n), 32'd0);
    else if (exp_hit) check("hit_latency", 32'(n), 32'd1);
    ufp_rmask = '0;
    ufp_wmask = '0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  rm, wm;
    int          n;
    rst = 1'b1; sram_clr = 1'b1; resp_spur = 1'b0;
    ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; cur_tag = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0;
      end
    model_plru_reset();
    repeat (3) @(negedge clk);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_dfp", {30'd0, dfp_read, dfp_write}, 32'd0);
    check("rst_we", {28'd0, arr_we}, 32'd0);
    check("rst_fill_sel", {31'd0, fill_sel}, 32'd0);
    rst = 1'b0; sram_clr = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Spurious memory response while idle
    @(posedge clk);
    #2 resp_spur = 1'b1;
    @(posedge clk);
    #2 resp_spur = 1'b0;
    @(negedge clk);
    check("spur_idle_dfp", {30'd0, dfp_read, dfp_write}, 32'd0);
    check("spur_idle_hit", {31'd0, hit}, 32'd0);

    do_req(32'h0000_0104, 4'hF, 4'h0, 1'b0);
    do_req(32'h0000_0108, 4'h0, 4'h3, 1'b1);
    for (int t = 1; t < 4; t++) do_req(32'(t) << 9, 4'hF, 4'h0, 1'b0);
    do_req(32'h0, 4'hF, 4'h0, 1'b0);
    do_req(32'd4 << 9, 4'hF, 4'h0, 1'b0);
    do_req(32'd5 << 9, 4'h0, 4'hF, 1'b0);
    do_req(32'd4 << 9, 4'h1, 4'h0, 1'b0);
    do_req(32'd6 << 9, 4'hF, 4'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = {20'd0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 5'($urandom)};
      rm = '0; wm = '0;
      case ($urandom_range(0, 2))
        0:       rm = 4'($urandom_range(1, 15));
        1:       wm = 4'($urandom_range(1, 15));
        default: begin rm = 4'($urandom_range(1, 15)); wm = 4'($urandom_range(1, 15)); end
      endcase
      do_req(a, rm, wm, 1'b0);
    end

    // Reset while the controller waits in ALLOCATE
    mon_en   = 1'b0;
    mem_hold = 1'b1;
    a = {23'd77, 4'd5, 5'd0};
    cur_tag = a[31:9]; ufp_addr = a; ufp_rmask = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dfp_read && n < 50);
    check("reach_allocate", {31'd0, dfp_read}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ufp_rmask = '0;
    @(negedge clk);
    rst = 1'b0;
    ufp_addr = {23'd0, 4'd9, 5'd0};
    #1;
    check("rst_alloc_dfp_read", {31'd0, dfp_read}, 32'd0);
    check("rst_alloc_idle_index", {28'd0, arr_index}, 32'd9);
    check("rst_alloc_plru", {29'd0, dut.plru_q[0]}, 32'd0);
    model_plru_reset();
    mem_hold = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    do_req(a, 4'hF, 4'h0, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
- Control FSM for the 4-way set-associative data cache; sits directly upstream of the cache data handler.
- Latches a UFP request, compares tags against the indexed set, and on a hit drives the data handler's hit/read/write/way inputs.
- On a miss it selects a victim (invalid-first, then pseudo-LRU), writes back a dirty line over DFP, fills the new line, then re-compares.

Parameters:
- WAYS, 4: associativity (fixed at 4; PLRU tree is 3 bits).
- SETS, 16: number of sets.
- INDEX_WIDTH, 4: log2(SETS).
- OFFSET_WIDTH, 5: byte offset within a 32-byte line.
- TAG_WIDTH, 23: 32 - INDEX_WIDTH - OFFSET_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ufp_addr  in  32  request address; held stable by requester until ufp_resp.
- ufp_rmask  in  4  read byte mask; nonzero = read request.
- ufp_wmask  in  4  write byte mask; nonzero = write request (wins if both are nonzero).
- tag_rdata  in  WAYS*TAG_WIDTH  tags of the indexed set, way0 in the LSBs (1-cycle SRAM read).
- valid_rdata  in  WAYS  valid bits of the indexed set.
- dirty_rdata  in  WAYS  dirty bits of the indexed set.
- arr_index  out  INDEX_WIDTH  set index to the arrays.
- arr_we  out  WAYS  one-hot write enable (data, tag, valid, dirty) for the selected way.
- arr_dirty_wdata  out  1  dirty value written with arr_we.
- fill_sel  out  1  1 = data array writes dfp_rdata; 0 = writes data-handler output.
- hit  out  1  to data handler.
- read  out  1  to data handler.
- write  out  1  to data handler.
- hit_way  out  2  way index of the hit.
- dfp_addr  out  32  line-aligned memory address.
- dfp_read  out  1  line read request.
- dfp_write  out  1  line write request (data = victim line from array).
- dfp_resp  in  1  memory completion, 1-cycle pulse.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset: state=IDLE; all SETS×3 PLRU bits = 0; all outputs 0; latched request cleared.
- arr_index = ufp_addr index field in IDLE; latched index in every other state.
- IDLE:
  - If (ufp_rmask|ufp_wmask) != 0, latch addr and masks, go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE (array outputs are valid this cycle):
  - Hit = some way w has valid_rdata[w] and tag_rdata[w] == latched tag.
  - On hit: hit=1; hit_way=w; write=|wmask; read=|rmask && !write.
  - On a write hit: also arr_we[w]=1 and arr_dirty_wdata=1.
  - On hit: update PLRU[index]; go to IDLE.
  - On miss: victim = lowest-numbered invalid way; if all ways are valid, victim = PLRU victim. Register the victim.
  - Miss with victim valid and dirty: go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - dfp_write=1 and dfp_addr={victim tag, index, 5'b0}, both held until dfp_resp.
  - On dfp_resp: go to ALLOCATE.
- ALLOCATE:
  - dfp_read=1 and dfp_addr={latched tag, index, 5'b0}, both held until dfp_resp.
  - On dfp_resp: arr_we[victim]=1, fill_sel=1, arr_dirty_wdata=0; go to STALL.
- STALL: one bubble for the SRAM write and re-read; go to COMPARE (guaranteed hit).
- Latency:
  - Hit: 2 cycles from request to hit.
  - Clean miss: 3 + memory latency.
  - Dirty miss: 3 + two memory latencies.
- PLRU, bits b0 b1 b2:
  - Victim: b0=0 selects way b1 (0 or 1); b0=1 selects way 2+b2.
  - Access way w: b0 = (w<2); if w<2 then b1 = (w==0), else b2 = (w==2).
  - Updated only on COMPARE hits; fills are counted by the following hit.
- dfp_resp outside WRITEBACK/ALLOCATE is ignored.
- dfp_read and dfp_write are never asserted together.
- Reset mid-operation abandons the request; DFP strobes drop the next cycle.
- hit/read/write/arr_we are combinational from state and registered data only (no ufp_* inputs) outside IDLE.

Decomposition:
- Shared cache package holds:
  - state enum {IDLE, COMPARE, WRITEBACK, ALLOCATE, STALL};
  - the tag/index/offset field widths and an address-split struct;
  - the line-alignment constant.
- Sub-module plru_tree4: pure combinational. Inputs: 3-bit state and access way. Outputs: victim and next state.

Test Plan:
- Cold read 0x0000_0104, rmask=4'hF: ALLOCATE with dfp_addr=0x0000_0100; after dfp_resp, STALL then COMPARE; hit=1, read=1, hit_way=0.
- Write hit at 0x0000_0108, wmask=4'h3: hit=1, write=1, arr_we=4'b0001, arr_dirty_wdata=1, one COMPARE cycle, no DFP activity.
- Fill set 0 with tags 0..3 (ways 0..3), then access tag 0 → PLRU victim=2. Miss on tag 4 allocates way 2 (arr_we=4'b0100).
- Dirty-victim miss: dfp_write first with the victim address {victim_tag, index, 5'b0}, then dfp_read of the new line. Strobes are never overlapping; a held dfp_resp=0 for 10 cycles keeps the addresses stable.
- rst asserted in ALLOCATE: next cycle dfp_read=0, state IDLE, PLRU bits 0. A subsequent request re-misses.
- Spurious dfp_resp in IDLE/COMPARE: no state change, arr_we=0.
